// File: rtl/vscale_dmem_responder_pkg.sv
// Shared definitions for the vscale data-memory responder.
// Holds the RV32 funct3 size encodings, the FSM state type, the wait-counter
// width, the store-lane payload struct and the lane/format helper functions.
package vscale_dmem_responder_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;

   // dmem_size encodings, identical to RV32 load/store funct3
   localparam logic [2:0] MEM_SIZE_B  = 3'd0;
   localparam logic [2:0] MEM_SIZE_H  = 3'd1;
   localparam logic [2:0] MEM_SIZE_W  = 3'd2;
   localparam logic [2:0] MEM_SIZE_BU = 3'd4;
   localparam logic [2:0] MEM_SIZE_HU = 3'd5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } dmem_state_e;

   // One store beat as presented to the RAM
   typedef struct packed {
      logic [3:0]      be;
      logic [XLEN-1:0] data;
   } store_lane_t;

   // Alignment and size legality; the range check lives in the responder
   function automatic logic size_err(input logic [2:0] size, input logic wen,
                                     input logic [1:0] off);
      logic e;
      e = 1'b0;
      case (size)
         MEM_SIZE_B:  e = 1'b0;
         MEM_SIZE_H:  e = off[0];
         MEM_SIZE_W:  e = (off != 2'd0);
         MEM_SIZE_BU: e = wen;
         MEM_SIZE_HU: e = wen | off[0];
         default:     e = 1'b1;
      endcase
      return e;
   endfunction

   // Byte enables and replicated data for a right-aligned store operand
   function automatic store_lane_t store_lanes(input logic [1:0] off,
                                               input logic [2:0] size,
                                               input logic [XLEN-1:0] wdata);
      store_lane_t s;
      s.be   = 4'b0000;
      s.data = '0;
      case (size)
         MEM_SIZE_B: begin
            s.be   = 4'b0001 << off;
            s.data = {4{wdata[7:0]}};
         end
         MEM_SIZE_H: begin
            s.be   = 4'b0011 << off;
            s.data = {2{wdata[15:0]}};
         end
         MEM_SIZE_W: begin
            s.be   = 4'b1111;
            s.data = wdata;
         end
         default: begin
            s.be   = 4'b0000;
            s.data = '0;
         end
      endcase
      return s;
   endfunction

   // Lane extraction plus sign/zero extension of a raw memory word
   function automatic logic [XLEN-1:0] load_format(input logic [XLEN-1:0] word,
                                                   input logic [1:0] off,
                                                   input logic [2:0] size);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         MEM_SIZE_B:  r = {{24{b[7]}}, b};
         MEM_SIZE_BU: r = {24'd0, b};
         MEM_SIZE_H:  r = {{16{h[15]}}, h};
         MEM_SIZE_HU: r = {16'd0, h};
         MEM_SIZE_W:  r = word;
         default:     r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vscale_sram_1rw.sv
// Word-organised RAM for the data-memory responder.
// One write port with per-byte enables and one registered read port; a read
// of a word being written in the same cycle returns the old contents.
// Ports: clk; we/be/waddr/wdata write side; re/raddr read request, rdata
// registered read data (holds while re is low). Contents are not reset.
module vscale_sram_1rw #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-masked write and registered read-old-data read
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale core dmem port.
// Accepts DX-stage requests, stalls the WB data phase for WAIT_CYCLES cycles,
// checks range/alignment/size, steers store lanes into the RAM and returns
// formatted load data. A load accepted while the previous store commits to the
// same word sees the stored bytes through a registered bypass.
// Ports: clk, reset (sync, active-high); dmem_en/dmem_wen/dmem_size/dmem_addr
// request (DX); dmem_wdata store data (WB); dmem_rdata, dmem_wait,
// dmem_badmem_e data-phase responses, all decoded from registered state.
module vscale_dmem_responder
   import vscale_dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_en,
   input  logic        dmem_wen,
   input  logic [2:0]  dmem_size,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_wait,
   output logic        dmem_badmem_e
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned TOP_LSB = AW + 2;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   dmem_state_e        state;
   logic [CNT_W-1:0]   cnt;
   logic [TOP_LSB-1:0] addr_q;
   logic               wen_q;
   logic [2:0]         size_q;
   logic               err_q;
   logic [3:0]         byp_be_q;
   logic [31:0]        byp_data_q;
   logic               fresh_q;
   logic [31:0]        hold_q;

   logic               complete;
   logic               accept;
   logic               commit;
   logic               req_err;
   logic               raw_hit;
   store_lane_t        lanes;
   logic [31:0]        ram_q;
   logic [31:0]        merge_word;
   logic [31:0]        load_word;

   // Handshake decode: completion cycle doubles as the next acceptance slot
   assign complete = (state == ST_DATA) && (cnt == '0);
   assign accept   = dmem_en && ((state == ST_IDLE) || complete);
   assign commit   = complete && wen_q && !err_q && !reset;

   // Fault detection on the incoming request
   always_comb begin
      req_err = ((dmem_addr >> TOP_LSB) != (BASE_ADDR >> TOP_LSB));
      if (size_err(dmem_size, dmem_wen, dmem_addr[1:0])) req_err = 1'b1;
   end

   assign lanes   = store_lanes(addr_q[1:0], size_q, dmem_wdata);
   // New request reads the word the finishing store is writing this edge
   assign raw_hit = accept && commit &&
                    (dmem_addr[TOP_LSB-1:2] == addr_q[TOP_LSB-1:2]);

   vscale_sram_1rw #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_sram (
      .clk   (clk),
      .we    (commit),
      .be    (lanes.be),
      .waddr (addr_q[TOP_LSB-1:2]),
      .wdata (lanes.data),
      .re    (accept && !reset),
      .raddr (dmem_addr[TOP_LSB-1:2]),
      .rdata (ram_q)
   );

   // Overlay bypassed store bytes on the old RAM word
   always_comb begin
      merge_word = ram_q;
      for (int i = 0; i < 4; i++) begin
         if (byp_be_q[i]) merge_word[8*i +: 8] = byp_data_q[8*i +: 8];
      end
   end

   // First data-phase cycle uses the RAM output directly, later cycles the hold copy
   assign load_word = fresh_q ? merge_word : hold_q;

   // Request tracking FSM, wait counter and read-data hold
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         size_q     <= MEM_SIZE_W;
         err_q      <= 1'b0;
         byp_be_q   <= 4'b0000;
         byp_data_q <= '0;
         fresh_q    <= 1'b0;
         hold_q     <= '0;
      end else begin
         fresh_q <= accept;
         if (fresh_q) hold_q <= merge_word;
         if (accept) begin
            state      <= ST_DATA;
            cnt        <= WAIT_INIT;
            addr_q     <= dmem_addr[TOP_LSB-1:0];
            wen_q      <= dmem_wen;
            size_q     <= dmem_size;
            err_q      <= req_err;
            byp_be_q   <= raw_hit ? lanes.be : 4'b0000;
            byp_data_q <= lanes.data;
         end else if (state == ST_DATA) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else           state <= ST_IDLE;
         end
      end
   end

   assign dmem_wait     = (state == ST_DATA) && (cnt != '0);
   assign dmem_badmem_e = complete && err_q;
   assign dmem_rdata    = (complete && !err_q && !wen_q) ?
                          load_format(load_word, addr_q[1:0], size_q) : '0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: one instance with no wait states and one
// with three, directed scenarios plus randomized traffic against a word-array
// memory model.
module tb_vscale_dmem_responder;

   logic        clk;
   logic        reset;
   logic        en    [2];
   logic        wen   [2];
   logic [2:0]  size  [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        dwait [2];
   logic        bad   [2];

   int n_checks;
   int n_errors;
   logic [31:0] mdl [2][1024];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vscale_dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .dmem_en(en[0]), .dmem_wen(wen[0]),
      .dmem_size(size[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
      .dmem_rdata(rdata[0]), .dmem_wait(dwait[0]), .dmem_badmem_e(bad[0]));

   vscale_dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut1 (
      .clk(clk), .reset(reset), .dmem_en(en[1]), .dmem_wen(wen[1]),
      .dmem_size(size[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
      .dmem_rdata(rdata[1]), .dmem_wait(dwait[1]), .dmem_badmem_e(bad[1]));

   function automatic int waits_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Reference rules: DEPTH=1024 words at base 0 -> valid bytes 0..4095
   function automatic logic exp_err(input logic [31:0] a, input logic w, input logic [2:0] sz);
      if (a >= 32'h1000) return 1'b1;
      case (sz)
         3'd0:    return 1'b0;
         3'd1:    return a[0];
         3'd2:    return (a % 4) != 0;
         3'd4:    return w;
         3'd5:    return w || a[0];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] sz);
      logic [31:0] sh;
      sh = word >> (8 * int'(off));
      case (sz)
         3'd0:    return {{24{sh[7]}}, sh[7:0]};
         3'd4:    return sh & 32'h0000_00FF;
         3'd1:    return {{16{sh[15]}}, sh[15:0]};
         3'd5:    return sh & 32'h0000_FFFF;
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] exp_store(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] sz, input logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      sh = 8 * int'(off);
      if (sz == 3'd0)      mask = 32'h0000_00FF << sh;
      else if (sz == 3'd1) mask = 32'h0000_FFFF << sh;
      else                 return wd;
      return (word & ~mask) | ((wd << sh) & mask);
   endfunction

   // One isolated access: request, stall count, sampled data-phase response
   task automatic access(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic bd,
                         output int stalls);
      @(negedge clk);
      en[d] = 1'b1; wen[d] = w; size[d] = sz; addr[d] = a;
      @(posedge clk); #1;
      en[d] = 1'b0; wdata[d] = wd; addr[d] = $urandom;
      stalls = 0;
      @(negedge clk);
      while (dwait[d] === 1'b1 && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 40) begin
         n_checks++; n_errors++;
         $display("FAIL timeout dut%0d addr=%h: dmem_wait stuck after %0d cycles, required drop", d, a, stalls);
      end
      rd = rdata[d]; bd = bad[d];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         en[d] = 1'b1; wen[d] = 1'b0; size[d] = 3'd2; addr[d] = 32'h100;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int d = 0; d < 2; d++) en[d] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (dwait[d] !== 1'b0) begin n_errors++; $display("FAIL reset_wait dut%0d got=%b want=0", d, dwait[d]); end
         n_checks++;
         if (bad[d] !== 1'b0) begin n_errors++; $display("FAIL reset_badmem dut%0d got=%b want=0", d, bad[d]); end
         n_checks++;
         if (rdata[d] !== 32'h0) begin n_errors++; $display("FAIL reset_rdata dut%0d got=%h want=0", d, rdata[d]); end
      end
   endtask

   // SW then LW on consecutive cycles with no wait states
   task automatic test_raw_bypass;
      @(negedge clk);
      en[0] = 1'b1; wen[0] = 1'b1; size[0] = 3'd2; addr[0] = 32'h10;
      @(negedge clk);
      wdata[0] = 32'hDEADBEEF;
      wen[0] = 1'b0; size[0] = 3'd2; addr[0] = 32'h10;
      n_checks++;
      if (dwait[0] !== 1'b0) begin n_errors++; $display("FAIL raw_store_wait got=%b want=0", dwait[0]); end
      @(negedge clk);
      en[0] = 1'b0; wdata[0] = 32'h0;
      n_checks++;
      if (dwait[0] !== 1'b0) begin n_errors++; $display("FAIL raw_load_wait got=%b want=0", dwait[0]); end
      n_checks++;
      if (rdata[0] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL raw_load_data got=%h want=deadbeef", rdata[0]); end
      n_checks++;
      if (bad[0] !== 1'b0) begin n_errors++; $display("FAIL raw_load_badmem got=%b want=0", bad[0]); end
      @(negedge clk);
   endtask

   task automatic test_subword;
      logic [31:0] rd; logic bd; int st;
      logic [2:0]  sz_t [4];
      logic [31:0] a_t  [4];
      logic [31:0] ex_t [4];
      sz_t = '{3'd0, 3'd4, 3'd1, 3'd5};
      a_t  = '{32'h23, 32'h23, 32'h22, 32'h20};
      ex_t = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      access(0, 1'b1, 3'd2, 32'h20, 32'h80FF7F01, rd, bd, st);
      for (int i = 0; i < 4; i++) begin
         access(0, 1'b0, sz_t[i], a_t[i], 32'h0, rd, bd, st);
         n_checks++;
         if (rd !== ex_t[i] || bd !== 1'b0)
            begin n_errors++; $display("FAIL subword_load%0d got=%h/%b want=%h/0", i, rd, bd, ex_t[i]); end
      end
   endtask

   task automatic test_lane_steer;
      logic [31:0] rd; logic bd; int st;
      access(0, 1'b1, 3'd2, 32'h30, 32'h11223344, rd, bd, st);
      access(0, 1'b1, 3'd0, 32'h31, 32'h000000AB, rd, bd, st);
      access(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, bd, st);
      n_checks++;
      if (rd !== 32'h1122AB44) begin n_errors++; $display("FAIL sb_lane got=%h want=1122ab44", rd); end
      access(0, 1'b1, 3'd1, 32'h32, 32'h0000CAFE, rd, bd, st);
      access(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, bd, st);
      n_checks++;
      if (rd !== 32'hCAFEAB44) begin n_errors++; $display("FAIL sh_lane got=%h want=cafeab44", rd); end
   endtask

   task automatic test_faults;
      logic [31:0] rd; logic bd; int st;
      access(0, 1'b1, 3'd2, 32'h40, 32'h0BADF00D, rd, bd, st);
      access(0, 1'b0, 3'd2, 32'h42, 32'h0, rd, bd, st);
      n_checks++;
      if (bd !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL lw_misaligned got=%b/%h want=1/0", bd, rd); end
      access(0, 1'b1, 3'd1, 32'h41, 32'h0000FFFF, rd, bd, st);
      n_checks++;
      if (bd !== 1'b1) begin n_errors++; $display("FAIL sh_misaligned got=%b want=1", bd); end
      access(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, bd, st);
      n_checks++;
      if (rd !== 32'h0BADF00D || bd !== 1'b0) begin n_errors++; $display("FAIL sh_no_write got=%h/%b want=0badf00d/0", rd, bd); end
      access(0, 1'b0, 3'd2, 32'h1000, 32'h0, rd, bd, st);
      n_checks++;
      if (bd !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL lw_range got=%b/%h want=1/0", bd, rd); end
      access(0, 1'b1, 3'd4, 32'h40, 32'h000000FF, rd, bd, st);
      n_checks++;
      if (bd !== 1'b1) begin n_errors++; $display("FAIL sbu_store got=%b want=1", bd); end
      access(0, 1'b0, 3'd3, 32'h40, 32'h0, rd, bd, st);
      n_checks++;
      if (bd !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL size3_load got=%b/%h want=1/0", bd, rd); end
      access(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, bd, st);
      n_checks++;
      if (rd !== 32'h0BADF00D) begin n_errors++; $display("FAIL sbu_no_write got=%h want=0badf00d", rd); end
   endtask

   // LW with a second LW held on the bus through the stall
   task automatic test_wait_states;
      logic [31:0] rd; logic bd; int st;
      logic ew;
      access(1, 1'b1, 3'd2, 32'h50, 32'hA1A2A3A4, rd, bd, st);
      n_checks++;
      if (st != 3) begin n_errors++; $display("FAIL store_stalls got=%0d want=3", st); end
      access(1, 1'b1, 3'd2, 32'h54, 32'hB1B2B3B4, rd, bd, st);
      @(negedge clk);
      en[1] = 1'b1; wen[1] = 1'b0; size[1] = 3'd2; addr[1] = 32'h50;
      @(posedge clk); #1;
      addr[1] = 32'h54;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ew = ((i % 4) != 3);
         n_checks++;
         if (dwait[1] !== ew) begin n_errors++; $display("FAIL wait_cycle%0d got=%b want=%b", i, dwait[1], ew); end
         if (i == 3) begin
            n_checks++;
            if (rdata[1] !== 32'hA1A2A3A4) begin n_errors++; $display("FAIL wait_first_data got=%h want=a1a2a3a4", rdata[1]); end
         end
         if (i == 4) en[1] = 1'b0;
         if (i == 7) begin
            n_checks++;
            if (rdata[1] !== 32'hB1B2B3B4) begin n_errors++; $display("FAIL wait_second_data got=%h want=b1b2b3b4", rdata[1]); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access;
      logic [31:0] rd; logic bd; int st;
      access(1, 1'b1, 3'd2, 32'h0, 32'hA5A5A5A5, rd, bd, st);
      @(negedge clk);
      en[1] = 1'b1; wen[1] = 1'b1; size[1] = 3'd2; addr[1] = 32'h0;
      @(posedge clk); #1;
      en[1] = 1'b0; wdata[1] = 32'h55;
      @(negedge clk);
      n_checks++;
      if (dwait[1] !== 1'b1) begin n_errors++; $display("FAIL mid_wait1 got=%b want=1", dwait[1]); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (dwait[1] !== 1'b0 || bad[1] !== 1'b0 || rdata[1] !== 32'h0)
            begin n_errors++; $display("FAIL mid_reset_idle%0d got=%b/%b/%h want=0/0/0", i, dwait[1], bad[1], rdata[1]); end
      end
      access(1, 1'b0, 3'd2, 32'h0, 32'h0, rd, bd, st);
      n_checks++;
      if (rd !== 32'hA5A5A5A5 || st != 3) begin n_errors++; $display("FAIL mid_reset_old got=%h/%0d want=a5a5a5a5/3", rd, st); end
   endtask

   task automatic test_random(input int d);
      logic [31:0] rd, a, wd, erd; logic bd, w, eb; int st;
      logic [2:0] sz;
      logic [2:0] sz_tab [16];
      sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2,
                 3'd4, 3'd5, 3'd2, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0};
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         a  = 32'h100 + 32'(4 * i);
         access(d, 1'b1, 3'd2, a, wd, rd, bd, st);
         mdl[d][a[11:2]] = wd;
         n_checks++;
         if (bd !== 1'b0) begin n_errors++; $display("FAIL rnd_fill dut%0d addr=%h got=%b want=0", d, a, bd); end
      end
      for (int i = 0; i < 80; i++) begin
         sz = sz_tab[$urandom_range(0, 15)];
         w  = 1'($urandom_range(0, 1));
         wd = $urandom;
         if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
         else                            a = 32'h100 + 32'($urandom_range(0, 63));
         eb  = exp_err(a, w, sz);
         erd = (eb || w) ? 32'h0 : exp_load(mdl[d][a[11:2]], a[1:0], sz);
         access(d, w, sz, a, wd, rd, bd, st);
         if (!eb && w) mdl[d][a[11:2]] = exp_store(mdl[d][a[11:2]], a[1:0], sz, wd);
         n_checks++;
         if (bd !== eb || rd !== erd || st != waits_of(d))
            begin n_errors++; $display("FAIL rnd dut%0d op%0d w=%b sz=%0d a=%h got=%b/%h/%0d want=%b/%h/%0d", d, i, w, sz, a, bd, rd, st, eb, erd, waits_of(d)); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         en[d] = 1'b0; wen[d] = 1'b0; size[d] = 3'd2; addr[d] = 32'h0; wdata[d] = 32'h0;
      end
      test_reset();
      test_raw_bypass();
      test_subword();
      test_lane_steer();
      test_faults();
      test_wait_states();
      test_reset_mid_access();
      test_random(0);
      test_random(1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
